// File: rtl/adc128s_spi_model.sv
// Behavioural model of an 8-channel 12-bit SPI A/D converter (mode 3 slave).
// Each transaction returns the channel addressed by the previous command.
module adc128s_spi_model (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  localparam logic [4:0] RISE_FULL = 5'd16;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  r_ss_sync;
  logic [2:0]  r_sclk_sync;
  logic [1:0]  r_mosi_sync;

  logic [2:0]  r_chan_ptr;
  logic [15:0] r_tx_shift;
  logic [13:0] r_rx_shift;
  logic [4:0]  r_rise_cnt;
  logic        r_first_fall;

  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_sclk_fall;
  logic        w_sclk_rise;
  logic        w_load;
  logic        w_rise_en;
  logic        w_fall_en;
  logic        w_commit;
  logic [11:0] w_chan_val;

  // Two flops resynchronize the pins; the third stage gives edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, making the shift chains order-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_sync   <= 3'b111;
      r_sclk_sync <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_ss_sync   <= {r_ss_sync[1:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_ss_fall   =  r_ss_sync[2]   & ~r_ss_sync[1];
  assign w_ss_rise   = ~r_ss_sync[2]   &  r_ss_sync[1];
  assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];
  assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_ss_fall) w_next_state = ST_XFER;
      ST_XFER: if (w_ss_rise) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_rise_en = 1'b0;
    w_fall_en = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      ST_IDLE: w_load = w_ss_fall;
      ST_XFER: begin
        w_rise_en = w_sclk_rise & ~w_ss_rise;
        w_fall_en = w_sclk_fall & ~w_ss_rise;
        w_commit  = w_ss_rise;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_chan_val = 12'h000;
    case (r_chan_ptr)
      3'd0:    w_chan_val = ld_cell_lft;
      3'd4:    w_chan_val = ld_cell_rght;
      3'd5:    w_chan_val = steerPot;
      3'd6:    w_chan_val = batt;
      default: w_chan_val = 12'h000;
    endcase
  end

  // Only command bits [13:11] are ever consumed, so two upper bits are not stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift   <= 16'h0000;
      r_rx_shift   <= 14'h0000;
      r_rise_cnt   <= 5'd0;
      r_first_fall <= 1'b0;
    end else if (w_load) begin
      r_tx_shift   <= {4'b0000, w_chan_val};
      r_rx_shift   <= 14'h0000;
      r_rise_cnt   <= 5'd0;
      r_first_fall <= 1'b0;
    end else begin
      if (w_rise_en) begin
        r_rx_shift <= {r_rx_shift[12:0], r_mosi_sync[1]};
        if (r_rise_cnt != RISE_FULL) begin
          r_rise_cnt <= r_rise_cnt + 5'd1;
        end
      end
      // The leading mode-3 fall only arms the shifter; bit 15 is already on MISO.
      if (w_fall_en) begin
        if (!r_first_fall) begin
          r_first_fall <= 1'b1;
        end else begin
          r_tx_shift <= {r_tx_shift[14:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chan_ptr <= 3'd0;
    end else if (w_commit && (r_rise_cnt == RISE_FULL)) begin
      r_chan_ptr <= r_rx_shift[13:11];
    end
  end

  assign MISO = r_tx_shift[15];

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Self-checking bench for adc128s_spi_model: an SPI mode-3 master drives
// transactions and compares returned words against a channel-pipeline model.
module tb_adc128s_spi_model;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] ld_cell_lft;
  logic [11:0] ld_cell_rght;
  logic [11:0] steerPot;
  logic [11:0] batt;

  int          n_checks;
  int          n_fail;
  logic [2:0]  model_ptr;

  adc128s_spi_model dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, required end before 500us");
    $fatal(1, "watchdog expired");
  end

  // Channel map straight from the converter's address table.
  function automatic logic [11:0] chan_value(input logic [2:0] ch);
    case (ch)
      3'd0:    return ld_cell_lft;
      3'd4:    return ld_cell_rght;
      3'd5:    return steerPot;
      3'd6:    return batt;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [15:0] top_mask(input int nbits);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < nbits; i++) m[15-i] = 1'b1;
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    ld_cell_lft  = 12'($urandom);
    ld_cell_rght = 12'($urandom);
    steerPot     = 12'($urandom);
    batt         = 12'($urandom);
  endtask

  task automatic sclk_bit(input logic mosi_bit, output logic miso_bit);
    SCLK = 1'b0;
    MOSI = mosi_bit;
    tick(10);
    miso_bit = MISO;
    SCLK = 1'b1;
    tick(10);
  endtask

  // One master transaction of nbits SCLK cycles; exp is the model's word and
  // the model pointer advances only on a complete 16-cycle command.
  task automatic run_xfer(input logic [15:0] cmd, input int nbits, input bit mid_change,
                          output logic [15:0] word, output logic [15:0] exp);
    logic b;
    exp  = {4'h0, chan_value(model_ptr)};
    word = 16'h0000;
    SS_n = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (mid_change && i == 5) randomize_inputs();
      sclk_bit(cmd[15-i], b);
      word[15-i] = b;
    end
    tick(6);
    SS_n = 1'b1;
    tick(10);
    if (nbits == 16) model_ptr = cmd[13:11];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (MISO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_miso: got %b expected 0", MISO);
    end
    n_checks++;
    if (dut.r_chan_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: got %0d expected 0", dut.r_chan_ptr);
    end
    rst = 1'b0;
    tick(5);
    n_checks++;
    if (MISO !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_miso: got %b expected 0", MISO);
    end
  endtask

  task automatic test_channel_map();
    logic [15:0] w;
    logic [15:0] e;
    ld_cell_lft = 12'd330;
    run_xfer(16'h2000, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h014A) begin
      n_fail++;
      $display("FAIL map_ch0: got %h expected 014a", w);
    end
    n_checks++;
    if (dut.r_chan_ptr !== 3'd4) begin
      n_fail++;
      $display("FAIL map_ptr4: got %0d expected 4", dut.r_chan_ptr);
    end
    ld_cell_rght = 12'h5A5;
    run_xfer(16'h2800, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h05A5) begin
      n_fail++;
      $display("FAIL map_ch4: got %h expected 05a5", w);
    end
    n_checks++;
    if (dut.r_chan_ptr !== 3'd5) begin
      n_fail++;
      $display("FAIL map_ptr5: got %0d expected 5", dut.r_chan_ptr);
    end
    steerPot = 12'h800;
    batt     = 12'hFFF;
    run_xfer(16'h3000, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h0800) begin
      n_fail++;
      $display("FAIL map_ch5: got %h expected 0800", w);
    end
    run_xfer(16'h1000, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h0FFF) begin
      n_fail++;
      $display("FAIL map_ch6: got %h expected 0fff", w);
    end
    run_xfer(16'h0000, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h0000) begin
      n_fail++;
      $display("FAIL map_ch2: got %h expected 0000", w);
    end
  endtask

  task automatic test_abort();
    logic [15:0] w;
    logic [15:0] e;
    ld_cell_lft = 12'h3C7;
    run_xfer(16'h3000, 8, 1'b0, w, e);
    n_checks++;
    if ((w & 16'hFF00) !== 16'h0300) begin
      n_fail++;
      $display("FAIL abort_partial: got %h expected 03xx", w);
    end
    n_checks++;
    if (dut.r_chan_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_ptr: got %0d expected 0", dut.r_chan_ptr);
    end
    run_xfer(16'h2000, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h03C7) begin
      n_fail++;
      $display("FAIL abort_next: got %h expected 03c7", w);
    end
  endtask

  task automatic test_idle_ss();
    logic [15:0] w;
    logic [15:0] e;
    ld_cell_rght = 12'h123;
    SS_n = 1'b0;
    tick(12);
    SS_n = 1'b1;
    tick(10);
    n_checks++;
    if (dut.r_chan_ptr !== 3'd4) begin
      n_fail++;
      $display("FAIL no_sclk_ptr: got %0d expected 4", dut.r_chan_ptr);
    end
    MOSI = 1'b1;
    for (int i = 0; i < 16; i++) begin
      SCLK = 1'b0;
      tick(10);
      SCLK = 1'b1;
      tick(10);
    end
    n_checks++;
    if (dut.r_chan_ptr !== 3'd4) begin
      n_fail++;
      $display("FAIL ss_high_sclk_ptr: got %0d expected 4", dut.r_chan_ptr);
    end
    run_xfer(16'h2800, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h0123) begin
      n_fail++;
      $display("FAIL idle_next: got %h expected 0123", w);
    end
  endtask

  task automatic test_mid_change();
    logic [15:0] w;
    logic [15:0] e;
    steerPot = 12'hABC;
    run_xfer(16'h3000, 16, 1'b1, w, e);
    n_checks++;
    if (w !== 16'h0ABC) begin
      n_fail++;
      $display("FAIL mid_change: got %h expected 0abc", w);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [15:0] e;
    logic [15:0] cmd;
    logic [15:0] m;
    int          nbits;
    bit          mid;
    for (int t = 0; t < 24; t++) begin
      randomize_inputs();
      cmd   = 16'($urandom);
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      mid   = 1'($urandom_range(0, 1));
      run_xfer(cmd, nbits, mid, w, e);
      m = top_mask(nbits);
      if (nbits > 0) begin
        n_checks++;
        if ((w & m) !== (e & m)) begin
          n_fail++;
          $display("FAIL rand_word[%0d]: got %h expected %h (mask %h)", t, w, e, m);
        end
      end
      n_checks++;
      if (dut.r_chan_ptr !== model_ptr) begin
        n_fail++;
        $display("FAIL rand_ptr[%0d]: got %0d expected %0d", t, dut.r_chan_ptr, model_ptr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    logic [15:0] e;
    logic        b;
    batt = 12'hFFF;
    run_xfer(16'h3000, 16, 1'b0, w, e);
    SS_n = 1'b0;
    tick(6);
    for (int i = 0; i < 6; i++) sclk_bit(1'b0, b);
    n_checks++;
    if (b !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_miso: got %b expected 1", b);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (MISO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_miso: got %b expected 0", MISO);
    end
    n_checks++;
    if (dut.r_chan_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_ptr: got %0d expected 0", dut.r_chan_ptr);
    end
    SS_n = 1'b1;
    tick(5);
    rst = 1'b0;
    model_ptr = 3'd0;
    tick(10);
    ld_cell_lft = 12'h9C3;
    run_xfer(16'h2000, 16, 1'b0, w, e);
    n_checks++;
    if (w !== 16'h09C3) begin
      n_fail++;
      $display("FAIL reset_mid_next: got %h expected 09c3", w);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    model_ptr    = 3'd0;
    rst          = 1'b1;
    SS_n         = 1'b1;
    SCLK         = 1'b1;
    MOSI         = 1'b0;
    ld_cell_lft  = 12'h000;
    ld_cell_rght = 12'h000;
    steerPot     = 12'h000;
    batt         = 12'h000;
    test_reset();
    test_channel_map();
    test_abort();
    test_idle_ss();
    test_mid_change();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
